// File: rtl/saturn_mem_bridge_pkg.sv
// Shared types and default external base addresses for the Saturn memory bridge.
package saturn_mem_bridge_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef enum logic [1:0] {REG_ROM, REG_RAML, REG_RAMH} region_t;

  localparam logic [21:0] ROM_BASE_DEF  = 22'h000000;
  localparam logic [21:0] RAML_BASE_DEF = 22'h040000;
  localparam logic [21:0] RAMH_BASE_DEF = 22'h080000;

endpackage

// File: rtl/saturn_mem_bridge_decode.sv
// Combinational region decode: picks the selected region and produces per-half word addresses, byte enables and skip flags.
module mem_region_decode
  import saturn_mem_bridge_pkg::*;
#(
  parameter logic [21:0] ROM_BASE  = ROM_BASE_DEF,
  parameter logic [21:0] RAML_BASE = RAML_BASE_DEF,
  parameter logic [21:0] RAMH_BASE = RAMH_BASE_DEF
) (
  input  logic        rom_cs_n,
  input  logic        raml_cs_n,
  input  logic        ramh_cs_n,
  input  logic [24:0] mem_a,
  input  logic [3:0]  mem_dqm_n,
  input  logic        mem_rd_n,
  output logic        sel,
  output region_t     region,
  output logic [21:0] addr_first,
  output logic [21:0] addr_second,
  output logic [1:0]  be_first,
  output logic [1:0]  be_second,
  output logic        skip_first,
  output logic        skip_second
);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_a[24:20], mem_a[0]};

  always_comb begin
    sel         = ~(rom_cs_n & raml_cs_n & ramh_cs_n);
    region      = REG_ROM;
    addr_first  = ROM_BASE + {4'b0, mem_a[18:1]};
    be_first    = 2'b11;
    be_second   = 2'b00;
    skip_first  = mem_rd_n;
    skip_second = 1'b1;

    if (rom_cs_n && !raml_cs_n) begin
      region     = REG_RAML;
      addr_first = RAML_BASE + {3'b0, mem_a[19:1]};
      be_first   = mem_rd_n ? ~mem_dqm_n[1:0] : 2'b11;
      skip_first = 1'b0;
    end else if (rom_cs_n && raml_cs_n) begin
      // High RAM is big-endian: the even word carries [31:16].
      region      = REG_RAMH;
      addr_first  = RAMH_BASE + {3'b0, mem_a[19:2], 1'b0};
      be_first    = mem_rd_n ? ~mem_dqm_n[3:2] : 2'b11;
      be_second   = mem_rd_n ? ~mem_dqm_n[1:0] : 2'b11;
      skip_first  = mem_rd_n && (mem_dqm_n[3:2] == 2'b11);
      skip_second = mem_rd_n && (mem_dqm_n[1:0] == 2'b11);
    end

    addr_second = addr_first + 22'd1;
  end

endmodule

// File: rtl/saturn_mem_bridge.sv
// Saturn core memory port to one 16-bit req/ack channel; high RAM accesses split into two halves, core stalled via MEM_WAIT_N.
module saturn_mem_bridge
  import saturn_mem_bridge_pkg::*;
#(
  parameter logic [21:0] ROM_BASE  = ROM_BASE_DEF,
  parameter logic [21:0] RAML_BASE = RAML_BASE_DEF,
  parameter logic [21:0] RAMH_BASE = RAMH_BASE_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [24:0] MEM_A,
  input  logic [31:0] MEM_DO,
  input  logic [3:0]  MEM_DQM_N,
  input  logic        MEM_RD_N,
  input  logic        ROM_CS_N,
  input  logic        RAML_CS_N,
  input  logic        RAMH_CS_N,
  output logic [31:0] MEM_DI,
  output logic        MEM_WAIT_N,
  output logic [21:0] EXT_A,
  output logic [15:0] EXT_D,
  output logic [1:0]  EXT_BE,
  output logic        EXT_WE,
  output logic        EXT_REQ,
  input  logic [15:0] EXT_Q,
  input  logic        EXT_ACK
);

  logic        sel;
  region_t     region;
  logic [21:0] addr_first, addr_second;
  logic [1:0]  be_first, be_second;
  logic        skip_first, skip_second;

  mem_region_decode #(
    .ROM_BASE (ROM_BASE),
    .RAML_BASE(RAML_BASE),
    .RAMH_BASE(RAMH_BASE)
  ) u_decode (
    .rom_cs_n   (ROM_CS_N),
    .raml_cs_n  (RAML_CS_N),
    .ramh_cs_n  (RAMH_CS_N),
    .mem_a      (MEM_A),
    .mem_dqm_n  (MEM_DQM_N),
    .mem_rd_n   (MEM_RD_N),
    .sel        (sel),
    .region     (region),
    .addr_first (addr_first),
    .addr_second(addr_second),
    .be_first   (be_first),
    .be_second  (be_second),
    .skip_first (skip_first),
    .skip_second(skip_second)
  );

  state_t      state_q, state_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_we_q, ext_we_d;
  logic [21:0] ext_a_q, ext_a_d;
  logic [1:0]  ext_be_q, ext_be_d;
  logic [15:0] ext_d_q, ext_d_d;
  logic [31:0] mem_di_q, mem_di_d;
  logic [15:0] d2_q, d2_d;
  logic [1:0]  be2_q, be2_d;
  logic [15:0] rdhi_q, rdhi_d;
  logic        wr_q, wr_d;
  logic        last_q, last_d;
  logic        ack;

  // An ACK only counts while a request is actually outstanding.
  assign ack = EXT_ACK & ext_req_q;

  always_comb begin
    state_d  = state_q;
    ext_req_d = ext_req_q;
    ext_we_d = ext_we_q;
    ext_a_d  = ext_a_q;
    ext_be_d = ext_be_q;
    ext_d_d  = ext_d_q;
    mem_di_d = mem_di_q;
    d2_d     = d2_q;
    be2_d    = be2_q;
    rdhi_d   = rdhi_q;
    wr_d     = wr_q;
    last_d   = last_q;

    unique case (state_q)
      IDLE: if (sel) begin
        wr_d   = MEM_RD_N;
        d2_d   = MEM_DO[15:0];
        be2_d  = be_second;
        last_d = skip_second;
        if (skip_first && skip_second) begin
          state_d = DONE;
        end else if (skip_first) begin
          state_d   = HI;
          ext_req_d = 1'b1;
          ext_we_d  = MEM_RD_N;
          ext_a_d   = addr_second;
          ext_be_d  = be_second;
          ext_d_d   = MEM_DO[15:0];
        end else begin
          state_d   = LO;
          ext_req_d = 1'b1;
          ext_we_d  = MEM_RD_N;
          ext_a_d   = addr_first;
          ext_be_d  = be_first;
          ext_d_d   = (region == REG_RAMH) ? MEM_DO[31:16] : MEM_DO[15:0];
        end
      end
      LO: if (ack) begin
        if (!last_q) begin
          state_d  = HI;
          ext_a_d  = ext_a_q + 22'd1;
          ext_be_d = be2_q;
          ext_d_d  = d2_q;
          if (!wr_q) rdhi_d = EXT_Q;
        end else begin
          state_d   = DONE;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          if (!wr_q) mem_di_d = {16'h0000, EXT_Q};
        end
      end
      HI: if (ack) begin
        state_d   = DONE;
        ext_req_d = 1'b0;
        ext_we_d  = 1'b0;
        if (!wr_q) mem_di_d = {rdhi_q, EXT_Q};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ext_req_q <= 1'b0;
      ext_we_q  <= 1'b0;
      ext_a_q   <= '0;
      ext_be_q  <= '0;
      ext_d_q   <= '0;
      mem_di_q  <= '0;
      d2_q      <= '0;
      be2_q     <= '0;
      rdhi_q    <= '0;
      wr_q      <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_req_q <= ext_req_d;
      ext_we_q  <= ext_we_d;
      ext_a_q   <= ext_a_d;
      ext_be_q  <= ext_be_d;
      ext_d_q   <= ext_d_d;
      mem_di_q  <= mem_di_d;
      d2_q      <= d2_d;
      be2_q     <= be2_d;
      rdhi_q    <= rdhi_d;
      wr_q      <= wr_d;
      last_q    <= last_d;
    end
  end

  assign MEM_DI     = mem_di_q;
  assign MEM_WAIT_N = RST | ~sel | (state_q == DONE);
  assign EXT_A      = ext_a_q;
  assign EXT_D      = ext_d_q;
  assign EXT_BE     = ext_be_q;
  assign EXT_WE     = ext_we_q;
  assign EXT_REQ    = ext_req_q;

endmodule

// File: tb/tb_saturn_mem_bridge.sv
// Self-checking bench: directed scenarios plus randomized accesses against a word-memory model of the external channel.
module tb_saturn_mem_bridge;

  localparam logic [21:0] ROM_B  = 22'h000000;
  localparam logic [21:0] RAML_B = 22'h040000;
  localparam logic [21:0] RAMH_B = 22'h080000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [24:0] MEM_A;
  logic [31:0] MEM_DO;
  logic [3:0]  MEM_DQM_N;
  logic        MEM_RD_N;
  logic        ROM_CS_N, RAML_CS_N, RAMH_CS_N;
  logic [31:0] MEM_DI;
  logic        MEM_WAIT_N;
  logic [21:0] EXT_A;
  logic [15:0] EXT_D;
  logic [1:0]  EXT_BE;
  logic        EXT_WE, EXT_REQ;
  logic [15:0] EXT_Q;
  logic        EXT_ACK;

  always #5 CLK = ~CLK;

  saturn_mem_bridge dut (
    .CLK(CLK), .RST(RST), .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DQM_N(MEM_DQM_N),
    .MEM_RD_N(MEM_RD_N), .ROM_CS_N(ROM_CS_N), .RAML_CS_N(RAML_CS_N), .RAMH_CS_N(RAMH_CS_N),
    .MEM_DI(MEM_DI), .MEM_WAIT_N(MEM_WAIT_N), .EXT_A(EXT_A), .EXT_D(EXT_D), .EXT_BE(EXT_BE),
    .EXT_WE(EXT_WE), .EXT_REQ(EXT_REQ), .EXT_Q(EXT_Q), .EXT_ACK(EXT_ACK)
  );

  int checks = 0;
  int failures = 0;

  // External memory model, 16-bit words.
  logic [15:0] mem [logic [21:0]];

  logic [21:0] log_a[$];
  logic [1:0]  log_be[$];
  logic [15:0] log_d[$];
  logic        log_we[$];
  int          obs_waits;
  bit          obs_done;
  bit          obs_unstable;
  logic [31:0] obs_di;

  function automatic logic [15:0] mem_rd(input logic [21:0] a);
    return mem.exists(a) ? mem[a] : (a[15:0] ^ {10'h0, a[21:16]} ^ 16'h5A3C);
  endfunction

  task automatic mem_wr(input logic [21:0] a, input logic [1:0] be, input logic [15:0] d);
    logic [15:0] cur;
    cur = mem_rd(a);
    if (be[1]) cur[15:8] = d[15:8];
    if (be[0]) cur[7:0]  = d[7:0];
    mem[a] = cur;
  endtask

  // Core + external responder: presents one access, acks each request after 'delay'
  // extra cycles, scrambles the access lines after capture, records what it saw.
  task automatic run_access(input logic [2:0] cs_n, input logic [24:0] a, input logic [31:0] dout,
                            input logic [3:0] dqm, input logic rd_n, input int delay, input bit keep_sel);
    int hold;
    {ROM_CS_N, RAML_CS_N, RAMH_CS_N} = cs_n;
    MEM_A = a; MEM_DO = dout; MEM_DQM_N = dqm; MEM_RD_N = rd_n;
    log_a.delete(); log_be.delete(); log_d.delete(); log_we.delete();
    obs_waits = 0; obs_done = 0; obs_unstable = 0; obs_di = 'x; hold = 0;
    for (int cyc = 0; cyc < 64 && !obs_done; cyc++) begin
      @(negedge CLK);
      EXT_ACK = 1'b0;
      if (EXT_REQ === 1'b1) begin
        if (hold == 0) begin
          log_a.push_back(EXT_A); log_be.push_back(EXT_BE);
          log_d.push_back(EXT_D); log_we.push_back(EXT_WE);
        end else if (EXT_A !== log_a[$] || EXT_BE !== log_be[$] || EXT_D !== log_d[$] || EXT_WE !== log_we[$]) begin
          obs_unstable = 1;
        end
        if (hold >= delay) begin
          EXT_ACK = 1'b1;
          hold = 0;
          if (EXT_WE) mem_wr(EXT_A, EXT_BE, EXT_D);
          else EXT_Q = mem_rd(EXT_A);
        end else begin
          hold++;
        end
      end
      if (MEM_WAIT_N === 1'b1) begin
        obs_done = 1; obs_di = MEM_DI;
      end else begin
        obs_waits++;
      end
      @(posedge CLK); #1;
      EXT_ACK = 1'b0; EXT_Q = 16'($urandom);
      MEM_A = 25'($urandom); MEM_DO = $urandom; MEM_DQM_N = 4'($urandom); MEM_RD_N = 1'($urandom);
    end
    if (!keep_sel) {ROM_CS_N, RAML_CS_N, RAMH_CS_N} = 3'b111;
  endtask

  task automatic test_reset;
    RST = 1'b1; ROM_CS_N = 1'b0; RAML_CS_N = 1'b1; RAMH_CS_N = 1'b1;
    MEM_A = '0; MEM_DO = '0; MEM_DQM_N = '0; MEM_RD_N = 1'b0; EXT_ACK = 1'b0; EXT_Q = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (MEM_WAIT_N !== 1'b1) begin failures++; $display("FAIL reset_wait got=%b exp=1", MEM_WAIT_N); end
    checks++; if (EXT_REQ !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", EXT_REQ); end
    checks++; if ({EXT_WE, EXT_BE, EXT_D, EXT_A} !== 41'h0) begin failures++;
      $display("FAIL reset_ext got we=%b be=%b d=%h a=%h exp all 0", EXT_WE, EXT_BE, EXT_D, EXT_A); end
    checks++; if (MEM_DI !== 32'h0) begin failures++; $display("FAIL reset_di got=%h exp=0", MEM_DI); end
    @(posedge CLK); #1;
    RST = 1'b0; ROM_CS_N = 1'b1;
  endtask

  task automatic test_rom_read;
    mem[22'h000081] = 16'h1234;
    run_access(3'b011, 25'h000102, 32'h0, 4'h0, 1'b0, 0, 0);
    checks++; if (!obs_done || log_a.size() != 1) begin failures++; $display("FAIL rom_rd_reqs got=%0d exp=1", log_a.size()); end
    checks++; if (log_a.size() > 0 && (log_a[0] !== 22'h000081 || log_be[0] !== 2'b11 || log_we[0] !== 1'b0)) begin failures++;
      $display("FAIL rom_rd_req got a=%h be=%b we=%b exp a=000081 be=11 we=0", log_a[0], log_be[0], log_we[0]); end
    checks++; if (obs_di !== 32'h00001234) begin failures++; $display("FAIL rom_rd_di got=%h exp=00001234", obs_di); end
    checks++; if (obs_waits != 2) begin failures++; $display("FAIL rom_rd_waits got=%0d exp=2", obs_waits); end
  endtask

  task automatic test_ramh_read;
    mem[22'h080008] = 16'hDEAD; mem[22'h080009] = 16'hBEEF;
    run_access(3'b110, 25'h000010, 32'h0, 4'h0, 1'b0, 0, 0);
    checks++; if (log_a.size() != 2 || log_a[0] !== 22'h080008 || log_a[1] !== 22'h080009) begin failures++;
      $display("FAIL ramh_rd_addr got n=%0d a0=%h a1=%h exp 080008,080009", log_a.size(), log_a[0], log_a[1]); end
    checks++; if (obs_di !== 32'hDEADBEEF) begin failures++; $display("FAIL ramh_rd_di got=%h exp=deadbeef", obs_di); end
    checks++; if (obs_waits != 3) begin failures++; $display("FAIL ramh_rd_waits got=%0d exp=3", obs_waits); end
  endtask

  task automatic test_ramh_byte_write;
    run_access(3'b110, 25'h000020, 32'hAABBCCDD, 4'b1110, 1'b1, 0, 0);
    checks++; if (log_a.size() != 1) begin failures++; $display("FAIL ramh_bw_reqs got=%0d exp=1", log_a.size()); end
    checks++; if (log_a.size() > 0 && (log_a[0] !== 22'h080011 || log_be[0] !== 2'b01 || log_d[0] !== 16'hCCDD || log_we[0] !== 1'b1)) begin
      failures++; $display("FAIL ramh_bw_req got a=%h be=%b d=%h we=%b exp a=080011 be=01 d=ccdd we=1",
                           log_a[0], log_be[0], log_d[0], log_we[0]); end
    checks++; if (obs_waits != 2) begin failures++; $display("FAIL ramh_bw_waits got=%0d exp=2", obs_waits); end
    checks++; if (obs_di !== 32'hDEADBEEF) begin failures++; $display("FAIL ramh_bw_di_hold got=%h exp=deadbeef", obs_di); end
  endtask

  task automatic test_no_req_writes;
    run_access(3'b001, 25'h000040, 32'h11223344, 4'h0, 1'b1, 0, 0);
    checks++; if (log_a.size() != 0 || obs_waits != 1) begin failures++;
      $display("FAIL rom_wr got reqs=%0d waits=%0d exp reqs=0 waits=1", log_a.size(), obs_waits); end
    run_access(3'b110, 25'h000044, 32'h55667788, 4'b1111, 1'b1, 0, 0);
    checks++; if (log_a.size() != 0 || obs_waits != 1) begin failures++;
      $display("FAIL ramh_masked_wr got reqs=%0d waits=%0d exp reqs=0 waits=1", log_a.size(), obs_waits); end
  endtask

  task automatic test_delayed_back_to_back;
    mem[22'h040100] = 16'h7E57;
    mem[22'h080042] = 16'hCAFE; mem[22'h080043] = 16'hF00D;
    run_access(3'b101, 25'h000200, 32'h0, 4'h0, 1'b0, 3, 1);
    checks++; if (log_a.size() != 1 || log_a[0] !== 22'h040100 || obs_unstable) begin failures++;
      $display("FAIL delay_req got n=%0d a=%h unstable=%0d exp n=1 a=040100 unstable=0", log_a.size(), log_a[0], obs_unstable); end
    checks++; if (obs_waits != 5 || obs_di !== 32'h00007E57) begin failures++;
      $display("FAIL delay_done got waits=%0d di=%h exp waits=5 di=00007e57", obs_waits, obs_di); end
    run_access(3'b110, 25'h000084, 32'h0, 4'h0, 1'b0, 0, 0);
    checks++; if (obs_waits != 3 || obs_di !== 32'hCAFEF00D) begin failures++;
      $display("FAIL b2b_ramh got waits=%0d di=%h exp waits=3 di=cafef00d", obs_waits, obs_di); end
  endtask

  task automatic test_reset_in_hi;
    mem[22'h080020] = 16'h1111; mem[22'h080021] = 16'h2222;
    ROM_CS_N = 1'b1; RAML_CS_N = 1'b1; RAMH_CS_N = 1'b0;
    MEM_A = 25'h000040; MEM_RD_N = 1'b0; MEM_DQM_N = 4'h0;
    @(negedge CLK);
    @(negedge CLK);
    EXT_ACK = 1'b1; EXT_Q = 16'h1111;
    @(posedge CLK); #1; EXT_ACK = 1'b0;
    @(negedge CLK);
    checks++; if (EXT_REQ !== 1'b1 || EXT_A !== 22'h080021) begin failures++;
      $display("FAIL rst_hi_pre got req=%b a=%h exp req=1 a=080021", EXT_REQ, EXT_A); end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; RAMH_CS_N = 1'b1;
    @(negedge CLK);
    checks++; if (EXT_REQ !== 1'b0 || MEM_DI !== 32'h0 || MEM_WAIT_N !== 1'b1) begin failures++;
      $display("FAIL rst_hi_post got req=%b di=%h wait=%b exp req=0 di=0 wait=1", EXT_REQ, MEM_DI, MEM_WAIT_N); end
    EXT_ACK = 1'b1; EXT_Q = 16'h2222;
    @(posedge CLK); #1; EXT_ACK = 1'b0;
    @(negedge CLK);
    checks++; if (EXT_REQ !== 1'b0 || MEM_DI !== 32'h0) begin failures++;
      $display("FAIL rst_hi_late_ack got req=%b di=%h exp req=0 di=0", EXT_REQ, MEM_DI); end
    @(posedge CLK); #1;
    run_access(3'b011, 25'h000102, 32'h0, 4'h0, 1'b0, 0, 0);
    checks++; if (obs_waits != 2 || obs_di !== 32'h00001234) begin failures++;
      $display("FAIL rst_hi_recover got waits=%0d di=%h exp waits=2 di=00001234", obs_waits, obs_di); end
  endtask

  task automatic test_random;
    logic [2:0]  cs;
    logic [24:0] a;
    logic [31:0] dout, model_di;
    logic [3:0]  dqm;
    logic        rd_n;
    int          dly, ex_n;
    logic [21:0] wa;
    logic [1:0]  be;
    logic [21:0] ex_a[2];
    logic [1:0]  ex_be[2];
    logic [15:0] ex_d[2];
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_di = 32'h0;
    for (int i = 0; i < 60; i++) begin
      cs = 3'($urandom_range(0, 6)); a = 25'($urandom); dout = $urandom;
      dqm = 4'($urandom); rd_n = 1'($urandom); dly = $urandom_range(0, 2);
      ex_n = 0;
      if (!cs[2]) begin
        wa = ROM_B + 22'((a >> 1) & 25'h3FFFF);
        if (!rd_n) begin
          ex_a[0] = wa; ex_be[0] = 2'b11; ex_n = 1; model_di = {16'h0, mem_rd(wa)};
        end
      end else if (!cs[1]) begin
        wa = RAML_B + 22'((a >> 1) & 25'h7FFFF);
        ex_a[0] = wa; ex_be[0] = rd_n ? ~dqm[1:0] : 2'b11; ex_d[0] = dout[15:0]; ex_n = 1;
        if (!rd_n) model_di = {16'h0, mem_rd(wa)};
      end else begin
        wa = RAMH_B + 22'(((a >> 2) & 25'h3FFFF) * 2);
        be = rd_n ? ~dqm[3:2] : 2'b11;
        if (be != 2'b00) begin ex_a[ex_n] = wa; ex_be[ex_n] = be; ex_d[ex_n] = dout[31:16]; ex_n++; end
        be = rd_n ? ~dqm[1:0] : 2'b11;
        if (be != 2'b00) begin ex_a[ex_n] = wa + 22'd1; ex_be[ex_n] = be; ex_d[ex_n] = dout[15:0]; ex_n++; end
        if (!rd_n) model_di = {mem_rd(wa), mem_rd(wa + 22'd1)};
      end
      run_access(cs, a, dout, dqm, rd_n, dly, 0);
      checks++; if (log_a.size() != ex_n) begin failures++;
        $display("FAIL rnd%0d_nreq got=%0d exp=%0d", i, log_a.size(), ex_n); end
      for (int j = 0; j < ex_n && j < log_a.size(); j++) begin
        checks++;
        if (log_a[j] !== ex_a[j] || log_be[j] !== ex_be[j] || log_we[j] !== rd_n || (rd_n && log_d[j] !== ex_d[j])) begin
          failures++; $display("FAIL rnd%0d_req%0d got a=%h be=%b we=%b d=%h exp a=%h be=%b we=%b d=%h", i, j,
                               log_a[j], log_be[j], log_we[j], log_d[j], ex_a[j], ex_be[j], rd_n, ex_d[j]); end
      end
      checks++; if (obs_waits != ((ex_n == 0) ? 1 : 1 + ex_n * (1 + dly))) begin failures++;
        $display("FAIL rnd%0d_waits got=%0d exp=%0d", i, obs_waits, (ex_n == 0) ? 1 : 1 + ex_n * (1 + dly)); end
      checks++; if (obs_di !== model_di) begin failures++;
        $display("FAIL rnd%0d_di got=%h exp=%h", i, obs_di, model_di); end
    end
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_ramh_read();
    test_ramh_byte_write();
    test_no_req_writes();
    test_delayed_back_to_back();
    test_reset_in_hi();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
